// File: rtl/dpwm_comparador_dt.sv
// -----------------------------------------------------------------------------
// dpwm_comparador_dt
//
// Purpose:
//   Compares the DPWM ramp coming from the progressive counter against a
//   double-buffered duty command and drives complementary high/low switch
//   gates separated by a programmable dead time.
//
// Ports:
//   CLK            system clock
//   RST_N          asynchronous, active-low reset
//   cuenta         ramp value (0,10,...,1000 then wraps to 0)
//   duty_in        requested duty in ramp units
//   duty_wr        one-cycle strobe capturing duty_in into the pending register
//   pwm_h          high-side gate
//   pwm_l          low-side gate
//   duty_activo    duty value applied during the current period
//   inicio_periodo one-cycle pulse at each period start
//   err_rango      last write exceeded DUTY_MAX and was saturated
//
// Parameters:
//   DT        dead-time length in CLK cycles (1..255)
//   DUTY_MAX  ramp full scale; larger commands are saturated
// -----------------------------------------------------------------------------
module dpwm_comparador_dt #(
    parameter int DT       = 4,
    parameter int DUTY_MAX = 1000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] cuenta,
    input  logic [9:0] duty_in,
    input  logic       duty_wr,
    output logic       pwm_h,
    output logic       pwm_l,
    output logic [9:0] duty_activo,
    output logic       inicio_periodo,
    output logic       err_rango
);

    localparam logic [9:0] DUTY_MAX_W = 10'(DUTY_MAX);
    localparam logic [7:0] DT_LOAD    = 8'(DT - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_DT_H,
        S_DT_L,
        S_ON_H,
        S_ON_L
    } state_t;

    state_t     state;
    logic [7:0] dt_count;
    logic [9:0] cuenta_q;
    logic [9:0] pending;
    logic       inicio;
    logic       raw;

    // A period starts on the first sample of 0 after a non-zero value, so a
    // ramp parked at 0 yields a single start. cuenta_q resets to 3FF so the
    // first 0 after reset is also recognised as a start.
    always_comb begin
        inicio = (cuenta == 10'd0) && (cuenta_q != 10'd0);
    end

    // Full-scale duty forces raw high across the wrap so the high side never
    // sees a dead-time gap at the period boundary.
    always_comb begin
        if (duty_activo >= DUTY_MAX_W) begin
            raw = 1'b1;
        end else begin
            raw = (cuenta_q < duty_activo);
        end
    end

    // Ramp sampling and the double-buffered duty registers. The active duty
    // only changes at a period start and always takes the pending value as it
    // was before this edge, so a coincident write lands one period later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cuenta_q       <= 10'h3FF;
            pending        <= 10'd0;
            duty_activo    <= 10'd0;
            err_rango      <= 1'b0;
            inicio_periodo <= 1'b0;
        end else begin
            cuenta_q       <= cuenta;
            inicio_periodo <= inicio;
            if (inicio) begin
                duty_activo <= pending;
            end
            if (duty_wr) begin
                if (duty_in > DUTY_MAX_W) begin
                    pending   <= DUTY_MAX_W;
                    err_rango <= 1'b1;
                end else begin
                    pending   <= duty_in;
                    err_rango <= 1'b0;
                end
            end
        end
    end

    // Gate FSM. Every change of raw passes through a dead-time state where
    // both gates are low; the gate only turns on once raw has held its new
    // value for DT further edges, so raw pulses shorter than DT are swallowed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_OFF;
            dt_count <= 8'd0;
            pwm_h    <= 1'b0;
            pwm_l    <= 1'b0;
        end else begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
            case (state)
                S_OFF: begin
                    dt_count <= DT_LOAD;
                    state    <= raw ? S_DT_H : S_DT_L;
                end
                S_DT_H: begin
                    if (!raw) begin
                        state    <= S_DT_L;
                        dt_count <= DT_LOAD;
                    end else if (dt_count == 8'd0) begin
                        state <= S_ON_H;
                        pwm_h <= 1'b1;
                    end else begin
                        dt_count <= dt_count - 8'd1;
                    end
                end
                S_DT_L: begin
                    if (raw) begin
                        state    <= S_DT_H;
                        dt_count <= DT_LOAD;
                    end else if (dt_count == 8'd0) begin
                        state <= S_ON_L;
                        pwm_l <= 1'b1;
                    end else begin
                        dt_count <= dt_count - 8'd1;
                    end
                end
                S_ON_H: begin
                    if (!raw) begin
                        state    <= S_DT_L;
                        dt_count <= DT_LOAD;
                    end else begin
                        pwm_h <= 1'b1;
                    end
                end
                S_ON_L: begin
                    if (raw) begin
                        state    <= S_DT_H;
                        dt_count <= DT_LOAD;
                    end else begin
                        pwm_l <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_OFF;
                    dt_count <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/dpwm_comparador_dt.md
Name: dpwm_comparador_dt

Overview:
- Reads the 10-bit DPWM ramp `cuenta` produced by the progressive counter. The ramp runs 0,10,…,1000, then wraps to 0; each value is held one or more CLK cycles.
- Compares the ramp against a double-buffered duty command.
- Drives complementary high/low switch gates with programmable dead time.
- Sits between the counter and the output pins of the DPWM.

Parameters:
- DT, 4, dead-time length in CLK cycles; legal range 1..255.
- DUTY_MAX, 1000, ramp full scale; duty commands above it are saturated.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous, active-low reset.
- cuenta  input  10  ramp value from the progressive counter; assumed stable across CLK edges.
- duty_in  input  10  requested duty, in ramp units (0..DUTY_MAX).
- duty_wr  input  1  one-cycle strobe; captures duty_in into the pending register.
- pwm_h  output  1  high-side gate.
- pwm_l  output  1  low-side gate.
- duty_activo  output  10  duty value currently in use.
- inicio_periodo  output  1  one-cycle pulse at each period start.
- err_rango  output  1  last write was out of range and was saturated.

Behaviour:
- Reset (RST_N low, asynchronous), immediately:
  - pwm_h=0, pwm_l=0, duty_activo=0, pending=0, err_rango=0, inicio_periodo=0.
  - FSM in S_OFF; cuenta_q=10'h3FF, so the first 0 after release is treated as a period start.
  - Reset asserted mid-operation has the same effect at any state.
- Sampling: cuenta_q <= cuenta on every edge.
- Period start: inicio = (cuenta==0) && (cuenta_q!=0), evaluated combinationally before the edge.
  - On that edge: duty_activo <= pending, and inicio_periodo pulses high for exactly one cycle.
  - cuenta held at 0 for several cycles produces only one pulse.
- Duty write: on an edge with duty_wr=1:
  - If duty_in>DUTY_MAX: pending <= DUTY_MAX and err_rango <= 1.
  - Otherwise: pending <= duty_in and err_rango <= 0.
- Write coinciding with a period start: duty_activo loads the OLD pending value; the new write applies from the following period. There is no bypass.
- Mid-period writes never change duty_activo, so there are no glitch pulses.
- Raw compare (combinational on cuenta_q and duty_activo):
  - raw = 1 if duty_activo >= DUTY_MAX.
  - Otherwise raw = (cuenta_q < duty_activo).
  - So duty 0 gives raw constantly low, and DUTY_MAX gives raw constantly high.
  - Values that are not multiples of 10 are legal; for example, 505 behaves like 510.
- Output FSM (registered outputs, 8-bit dead-time counter):
  - S_OFF: both low. Next edge goes to S_DT_H if raw=1, else S_DT_L, loading count=DT-1.
  - S_DT_H: both low. If raw=0, go to S_DT_L and reload DT-1. Else if count==0, go to S_ON_H. Else decrement.
  - S_DT_L: mirror of S_DT_H, with target S_ON_L.
  - S_ON_H: pwm_h=1. If raw=0, go to S_DT_L (pwm_h drops on that edge) and load DT-1.
  - S_ON_L: pwm_l=1. If raw=1, go to S_DT_H and load DT-1.
- Timing: let edge k sample a cuenta value that flips raw.
  - The conducting output deasserts at edge k+1.
  - The opposite output asserts at edge k+1+DT, provided raw is unchanged.
  - A raw pulse shorter than DT never asserts its output.
- Invariant: pwm_h and pwm_l are never both 1, in any state or through any reset.

Test Plan:
- Reset mid-conduction (pwm_h=1, duty 500): RST_N low -> pwm_h=pwm_l=0 and duty_activo=0 within the same cycle. After release with cuenta=0 -> inicio_periodo pulses once, then pwm_l=1 at edge 1+DT=5.
- Ramp at 10 cycles/step, duty 500, DT=4 -> every period pwm_h is high 496 cycles and pwm_l high 510-4=506 cycles, with a 4-cycle both-low gap at each transition. Checker asserts the pwm_h&pwm_l==0 invariant on every cycle.
- Shadow update: duty 500 active, duty_wr with 300 while cuenta=500 -> duty_activo stays 500 until cuenta returns to 0. The next period uses 300 (pwm_h high 296 cycles at 10 cycles/step).
- Saturation: duty_wr with 1023 -> err_rango=1 and pending=1000. Next period: pwm_h held high across the whole period including the wrap, pwm_l=0, no dead-time gaps. A later write of 200 clears err_rango.
- Short pulse: duty 10, 2 cycles/step, DT=4 -> pwm_h never asserts; pwm_l low for exactly 6 cycles per period, then returns high.
- Simultaneous event: pending=200, duty_wr=700 on the edge where cuenta goes 1000->0 -> duty_activo=200 for that period and 700 from the next inicio_periodo.
